// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-file responder: NUM_REGS x 32-bit registers with byte strobes,
// independent write/read FSMs, per-register write pulse and DECERR for unmapped indices.
module axil_reg_slave #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,

    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    input  logic [31:0]             s_axil_wdata,
    input  logic [3:0]              s_axil_wstrb,

    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [1:0]              s_axil_bresp,

    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,

    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,

    output logic [NUM_REGS*32-1:0]  reg_out,
    output logic [NUM_REGS-1:0]     wr_pulse
);

    localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned AIW  = ADDR_WIDTH - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_RESP } rstate_e;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({{(64-AIW){1'b0}}, a[ADDR_WIDTH-1:2]} < 64'(NUM_REGS));
    endfunction

    function automatic logic [IDXW-1:0] reg_sel(input logic [ADDR_WIDTH-1:0] a);
        return a[IDXW+1:2];
    endfunction

    logic [31:0]           regs_q [NUM_REGS];
    wstate_e               wstate_q;
    rstate_e               rstate_q;
    logic                  aw_done_q, w_done_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;

    logic                  aw_hs, w_hs, have_aw, have_w;
    logic [ADDR_WIDTH-1:0] waddr_eff;
    logic [31:0]           wdata_eff;
    logic [3:0]            wstrb_eff;

    assign s_axil_awready = (wstate_q == W_IDLE) && !aw_done_q;
    assign s_axil_wready  = (wstate_q == W_IDLE) && !w_done_q;
    assign s_axil_arready = (rstate_q == R_IDLE);

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid  && s_axil_wready;
    assign have_aw = aw_done_q || aw_hs;
    assign have_w  = w_done_q  || w_hs;

    // A channel arriving on the completing edge is used directly; an earlier one comes from its holding register.
    assign waddr_eff = aw_hs ? s_axil_awaddr : awaddr_q;
    assign wdata_eff = w_hs  ? s_axil_wdata  : wdata_q;
    assign wstrb_eff = w_hs  ? s_axil_wstrb  : wstrb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q   <= W_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            case (wstate_q)
                W_IDLE: begin
                    if (have_aw && have_w) begin
                        if (in_range(waddr_eff)) begin
                            for (int unsigned k = 0; k < 4; k++) begin
                                if (wstrb_eff[k]) begin
                                    regs_q[reg_sel(waddr_eff)][8*k +: 8] <= wdata_eff[8*k +: 8];
                                end
                            end
                            wr_pulse_q[reg_sel(waddr_eff)] <= 1'b1;
                            bresp_q <= RESP_OKAY;
                        end else begin
                            bresp_q <= RESP_DECERR;
                        end
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        wstate_q  <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_done_q <= 1'b1;
                            awaddr_q  <= s_axil_awaddr;
                        end
                        if (w_hs) begin
                            w_done_q <= 1'b1;
                            wdata_q  <= s_axil_wdata;
                            wstrb_q  <= s_axil_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs_q before any same-edge commit lands, so they return the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s_axil_arvalid) begin
                        if (in_range(s_axil_araddr)) begin
                            rdata_q <= regs_q[reg_sel(s_axil_araddr)];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_DECERR;
                        end
                        rvalid_q <= 1'b1;
                        rstate_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready) begin
                        rvalid_q <= 1'b0;
                        rstate_q <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
        assign reg_out[32*gi +: 32] = regs_q[gi];
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;
    assign wr_pulse      = wr_pulse_q;

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave (NUM_REGS=8, ADDR_WIDTH=32).
module tb_axil_reg_slave;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, araddr, wdata, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_out;
    logic [7:0]   wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [31:0] mreg [8];

    always #5 clk = ~clk;

    axil_reg_slave #(.NUM_REGS(8), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    function automatic logic [255:0] packed_regs();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = mreg[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = 3'b010; arprot = 3'b101;
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        #2;
        checks++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
            errors++; $display("FAIL reset_resp: got %b expected %b", {bvalid, rvalid, bresp, rresp}, 6'b0);
        end
        checks++;
        if (reg_out !== 256'b0 || wr_pulse !== 8'h00 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got reg_out=%h wr_pulse=%h rdata=%h expected zeros", reg_out, wr_pulse, rdata);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b expected %b", {awready, wready, arready}, 3'b111);
        end
    endtask

    task automatic test_same_cycle_write();
        awvalid = 1; awaddr = 32'h4; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 0;
        checks++;
        if ({awready, wready} !== 2'b11) begin
            errors++; $display("FAIL sc_ready: got %b expected %b", {awready, wready}, 2'b11);
        end
        step();
        awvalid = 0; wvalid = 0;
        mreg[1] = 32'hDEADBEEF;
        checks++;
        if ({bvalid, bresp} !== 3'b100 || wr_pulse !== 8'h02) begin
            errors++; $display("FAIL sc_resp: got bvalid/bresp=%b wr_pulse=%h expected 100 / 02", {bvalid, bresp}, wr_pulse);
        end
        checks++;
        if (reg_out !== packed_regs()) begin
            errors++; $display("FAIL sc_reg: got %h expected %h", reg_out, packed_regs());
        end
        checks++;
        if ({awready, wready} !== 2'b00) begin
            errors++; $display("FAIL sc_busy: got %b expected %b", {awready, wready}, 2'b00);
        end
        step();
        checks++;
        if (wr_pulse !== 8'h00 || bvalid !== 1'b1) begin
            errors++; $display("FAIL sc_pulse_once: got wr_pulse=%h bvalid=%b expected 00 1", wr_pulse, bvalid);
        end
        bready = 1;
        step();
        bready = 0;
        checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            errors++; $display("FAIL sc_release: got %b expected %b", {bvalid, awready, wready}, 3'b011);
        end
    endtask

    task automatic test_w_before_aw();
        wvalid = 1; wdata = 32'h11223344; wstrb = 4'h5;
        step();
        wvalid = 0;
        checks++;
        if ({wready, awready, bvalid} !== 3'b010) begin
            errors++; $display("FAIL wfirst_ready: got %b expected %b", {wready, awready, bvalid}, 3'b010);
        end
        step(); step();
        awvalid = 1; awaddr = 32'h0;
        step();
        awvalid = 0;
        mreg[0] = 32'h00220044;
        checks++;
        if ({bvalid, bresp} !== 3'b100 || wr_pulse !== 8'h01) begin
            errors++; $display("FAIL wfirst_resp: got bvalid/bresp=%b wr_pulse=%h expected 100 / 01", {bvalid, bresp}, wr_pulse);
        end
        checks++;
        if (reg_out !== packed_regs()) begin
            errors++; $display("FAIL wfirst_reg: got %h expected %h", reg_out, packed_regs());
        end
        bready = 1; step(); bready = 0;
    endtask

    task automatic test_out_of_range();
        awvalid = 1; awaddr = 32'h20; wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        step();
        awvalid = 0; wvalid = 0;
        checks++;
        if ({bvalid, bresp} !== 3'b111 || wr_pulse !== 8'h00) begin
            errors++; $display("FAIL oor_wr: got bvalid/bresp=%b wr_pulse=%h expected 111 / 00", {bvalid, bresp}, wr_pulse);
        end
        checks++;
        if (reg_out !== packed_regs()) begin
            errors++; $display("FAIL oor_reg: got %h expected %h", reg_out, packed_regs());
        end
        bready = 1; step(); bready = 0;
        arvalid = 1; araddr = 32'h20;
        step();
        arvalid = 0;
        checks++;
        if ({rvalid, rresp} !== 3'b111 || rdata !== 32'h0) begin
            errors++; $display("FAIL oor_rd: got rvalid/rresp=%b rdata=%h expected 111 / 00000000", {rvalid, rresp}, rdata);
        end
        rready = 1; step(); rready = 0;
    endtask

    task automatic test_stall();
        awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h4; bready = 0; rready = 0;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        mreg[3] = 32'h12345678;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({bvalid, bresp, rvalid, rresp} !== 6'b100100 || rdata !== 32'hDEADBEEF ||
                {awready, wready, arready} !== 3'b000) begin
                errors++; $display("FAIL stall_hold%0d: got b=%b r=%b rdata=%h rdy=%b expected 100 100 deadbeef 000",
                                   c, {bvalid, bresp}, {rvalid, rresp}, rdata, {awready, wready, arready});
            end
            step();
        end
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
        checks++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
            errors++; $display("FAIL stall_release: got %b expected %b", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
        end
        checks++;
        if (reg_out !== packed_regs()) begin
            errors++; $display("FAIL stall_reg: got %h expected %h", reg_out, packed_regs());
        end
    endtask

    task automatic test_same_edge_rw();
        awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'hA; wstrb = 4'hF; bready = 1;
        step();
        awvalid = 0; wvalid = 0;
        step();
        awvalid = 1; wvalid = 1; wdata = 32'hB; arvalid = 1; araddr = 32'h8; rready = 1;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        mreg[2] = 32'hB;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hA) begin
            errors++; $display("FAIL same_edge_old: got rvalid=%b rdata=%h expected 1 0000000a", rvalid, rdata);
        end
        checks++;
        if (reg_out !== packed_regs()) begin
            errors++; $display("FAIL same_edge_reg: got %h expected %h", reg_out, packed_regs());
        end
        step();
        arvalid = 1;
        step();
        arvalid = 0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hB) begin
            errors++; $display("FAIL same_edge_new: got rvalid=%b rdata=%h expected 1 0000000b", rvalid, rdata);
        end
        step();
        bready = 0; rready = 0;
    endtask

    task automatic test_back_to_back();
        int wcnt = 0, rcnt = 0, bad = 0;
        awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h55; wstrb = 4'hF; bready = 1;
        arvalid = 1; araddr = 32'h0; rready = 1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (wr_pulse[5]) wcnt++;
            if (rvalid) begin
                rcnt++;
                if (rdata !== 32'h00220044) bad++;
            end
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        mreg[5] = 32'h55;
        checks++;
        if (wcnt !== 5 || rcnt !== 5) begin
            errors++; $display("FAIL b2b_rate: got writes=%0d reads=%0d expected 5 5", wcnt, rcnt);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_rdata: got %0d wrong beats expected 0", bad);
        end
        checks++;
        if (reg_out !== packed_regs()) begin
            errors++; $display("FAIL b2b_reg: got %h expected %h", reg_out, packed_regs());
        end
        step();
        bready = 0; rready = 0;
    endtask

    task automatic test_reset_mid();
        awvalid = 1; awaddr = 32'h18; wvalid = 1; wdata = 32'h66; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h4;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        rst_n = 0;
        #2;
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        checks++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0 || rdata !== 32'h0 || wr_pulse !== 8'h00) begin
            errors++; $display("FAIL mid_async: got b/r=%b rdata=%h wr_pulse=%h expected zeros",
                               {bvalid, rvalid, bresp, rresp}, rdata, wr_pulse);
        end
        checks++;
        if (reg_out !== 256'b0) begin
            errors++; $display("FAIL mid_regs: got %h expected 0", reg_out);
        end
        step();
        rst_n = 1;
        step();
        checks++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
            errors++; $display("FAIL mid_after: got %b expected %b", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
        end
        wvalid = 1; wdata = 32'h77;
        step();
        wvalid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        awvalid = 1; awaddr = 32'h1C;
        step();
        awvalid = 0;
        step(); step();
        checks++;
        if ({bvalid, awready, wready} !== 3'b001 || reg_out !== 256'b0) begin
            errors++; $display("FAIL mid_flag_clear: got bvalid/awr/wr=%b reg_out=%h expected 001 0",
                               {bvalid, awready, wready}, reg_out);
        end
        wvalid = 1; wdata = 32'h99;
        step();
        wvalid = 0;
        mreg[7] = 32'h99;
        checks++;
        if (bvalid !== 1'b1 || wr_pulse !== 8'h80 || reg_out !== packed_regs()) begin
            errors++; $display("FAIL mid_complete: got bvalid=%b wr_pulse=%h reg_out=%h expected 1 80 %h",
                               bvalid, wr_pulse, reg_out, packed_regs());
        end
        bready = 1; step(); bready = 0;
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_out_of_range();
        test_stall();
        test_same_edge_rw();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
